// File: rtl/ascii_load_feeder.sv
// ============================================================================
// Module   : ascii_load_feeder
// Purpose  : Buffers an ioctl-downloaded ASCII file and paces it, one byte at
//            a time, into the UK101 serial receive path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_load_feeder #(
  parameter int FIFO_AW  = 8,
  parameter int GAP_W    = 24,
  parameter int CHAR_GAP = 48000,
  parameter int LINE_GAP = 4800000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_data,
  output logic       ioctl_wait,
  input  logic       abort,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int               c_DEPTH_I  = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] c_DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] c_WAIT_LVL = c_DEPTH - 2'd2;
  localparam logic [GAP_W-1:0] c_CHAR_GAP = GAP_W'(CHAR_GAP);
  localparam logic [GAP_W-1:0] c_LINE_GAP = GAP_W'(LINE_GAP);
  localparam logic [7:0]       c_CR       = 8'h0D;
  localparam logic [7:0]       c_LF       = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  logic [7:0]         r_mem [c_DEPTH_I];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_wait;
  logic               r_overflow;
  logic               r_last_cr;
  logic               r_dl_d;
  state_t             r_state;
  logic [GAP_W-1:0]   r_gap;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;

  logic               w_dl_start;
  logic               w_flush;
  logic               w_wr;
  logic               w_is_lf;
  logic               w_keep;
  logic [7:0]         w_wbyte;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [FIFO_AW:0]   w_count_nxt;
  state_t             w_state_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [7:0]         w_rx_data_nxt;
  logic               w_rx_valid_nxt;

  assign w_dl_start = ioctl_download & ~r_dl_d;
  assign w_flush    = abort | w_dl_start;
  assign w_wr       = ioctl_download & ioctl_wr & ~w_flush;

  // LF following CR is the second half of a CRLF pair; lone LF becomes CR.
  assign w_is_lf = (ioctl_data == c_LF);
  assign w_keep  = w_wr & (ioctl_data != 8'h00) & ~(w_is_lf & r_last_cr);
  assign w_wbyte = w_is_lf ? c_CR : ioctl_data;

  assign w_full = (r_count == c_DEPTH);
  assign w_pop  = (r_state == S_IDLE) & (r_count != '0) & ~w_flush;
  assign w_push = w_keep & (~w_full | w_pop);
  assign w_drop = w_keep & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wait     <= 1'b0;
      r_overflow <= 1'b0;
      r_last_cr  <= 1'b0;
      r_dl_d     <= 1'b0;
    end else begin
      r_dl_d  <= ioctl_download;
      r_count <= w_count_nxt;
      r_wait  <= (w_count_nxt >= c_WAIT_LVL);
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      if (w_dl_start)  r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
      if (w_dl_start)  r_last_cr <= 1'b0;
      else if (w_wr)   r_last_cr <= (ioctl_data == c_CR);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wbyte;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gap_nxt      = r_gap;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = r_rx_valid;
    if (w_flush) begin
      w_state_nxt    = S_IDLE;
      w_gap_nxt      = '0;
      w_rx_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            w_rx_data_nxt  = r_mem[r_rptr];
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (rx_ready) begin
            w_rx_valid_nxt = 1'b0;
            w_gap_nxt      = (r_rx_data == c_CR) ? c_LINE_GAP : c_CHAR_GAP;
            w_state_nxt    = S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap <= GAP_W'(1)) begin
            w_gap_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt = r_gap - 1'b1;
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_gap_nxt      = '0;
          w_rx_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign ioctl_wait = r_wait;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign overflow   = r_overflow;
  assign busy       = (r_count != '0) | (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ascii_load_feeder.sv
// ============================================================================
// Module   : tb_ascii_load_feeder
// Purpose  : Directed self-checking bench for ascii_load_feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascii_load_feeder;

  localparam int c_CHAR_GAP = 4;
  localparam int c_LINE_GAP = 20;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       ioctl_download = 1'b0;
  logic       ioctl_wr = 1'b0;
  logic [7:0] ioctl_data = 8'h00;
  logic       ioctl_wait;
  logic       abort = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         hs_t[$];
  int         rise_t[$];
  logic       prev_v = 1'b0;

  ascii_load_feeder #(
    .FIFO_AW (3),
    .GAP_W   (24),
    .CHAR_GAP(c_CHAR_GAP),
    .LINE_GAP(c_LINE_GAP)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_data    (ioctl_data),
    .ioctl_wait    (ioctl_wait),
    .abort         (abort),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge indices: a handshake seen in cycle N takes effect at edge N+1.
  always @(negedge clk) begin
    if (n_reset && rx_valid && rx_ready) begin
      rx_q.push_back(rx_data);
      hs_t.push_back(cyc + 1);
    end
    if (rx_valid && !prev_v) rise_t.push_back(cyc);
    prev_v = rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hFFFF;
  endfunction

  function automatic int t_at(input int i, input bit rise);
    if (rise) return (i < rise_t.size()) ? rise_t[i] : -1000;
    return (i < hs_t.size()) ? hs_t[i] : -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    ioctl_data = b;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic start_dl();
    ioctl_download = 1'b0;
    tick();
    tick();
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic clear_mon();
    rx_q.delete();
    hs_t.delete();
    rise_t.delete();
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int t);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    t = cyc;
    check(tag, {31'h0, busy}, 0);
  endtask

  initial begin
    int t;
    logic [7:0] s2 [4] = '{8'h58, 8'h0D, 8'h59, 8'h5A};

    #3;
    check("rst_rx_valid", {31'h0, rx_valid}, 0);
    check("rst_rx_data", {24'h0, rx_data}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_wait", {31'h0, ioctl_wait}, 0);
    check("rst_overflow", {31'h0, overflow}, 0);
    tick();
    tick();
    n_reset = 1'b1;
    tick();

    // "AB\r\n" with consumer always ready
    rx_ready = 1'b1;
    clear_mon();
    start_dl();
    wr(8'h41); wr(8'h42); wr(8'h0D); wr(8'h0A);
    wait_rx(3, 200, "t1_count");
    wait_idle(200, "t1_idle", t);
    check("t1_size", rx_q.size(), 3);
    check("t1_b0", q_at(0), 8'h41);
    check("t1_b1", q_at(1), 8'h42);
    check("t1_b2", q_at(2), 8'h0D);
    check("t1_char_gap0", t_at(1, 1'b1) - t_at(0, 1'b0), c_CHAR_GAP + 1);
    check("t1_char_gap1", t_at(2, 1'b1) - t_at(1, 1'b0), c_CHAR_GAP + 1);
    check("t1_line_gap", t - t_at(2, 1'b0), c_LINE_GAP);

    // "X\nY\0Z"; download ends before draining
    clear_mon();
    start_dl();
    wr(8'h58); wr(8'h0A); wr(8'h59); wr(8'h00); wr(8'h5A);
    ioctl_download = 1'b0;
    wait_rx(4, 300, "t2_count");
    wait_idle(300, "t2_idle", t);
    check("t2_size", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_b%0d", i), q_at(i), s2[i]);

    // Backpressure, overflow and stalled consumer
    rx_ready = 1'b0;
    clear_mon();
    start_dl();
    for (int i = 0; i < 10; i++) begin
      wr(8'h30 + 8'(i));
      if (i == 5) check("t3_wait_lo", {31'h0, ioctl_wait}, 0);
      if (i == 6) check("t3_wait_hi", {31'h0, ioctl_wait}, 1);
      if (i == 8) check("t3_ovf_lo", {31'h0, overflow}, 0);
      if (i == 9) check("t3_ovf_hi", {31'h0, overflow}, 1);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_valid_hold", {31'h0, rx_valid}, 1);
      check("t4_data_hold", {24'h0, rx_data}, 8'h30);
      check("t4_wait_hold", {31'h0, ioctl_wait}, 1);
    end
    check("t4_no_handshake", rx_q.size(), 0);
    rx_ready = 1'b1;
    wait_rx(9, 400, "t3_count");
    wait_idle(200, "t3_idle", t);
    check("t3_size", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("t3_b%0d", i), q_at(i), 8'h30 + i);
    check("t3_ovf_sticky", {31'h0, overflow}, 1);

    // Abort with four bytes queued
    rx_ready = 1'b0;
    clear_mon();
    start_dl();
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44); wr(8'h45);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_valid", {31'h0, rx_valid}, 0);
    check("t5_busy", {31'h0, busy}, 0);
    check("t5_wait", {31'h0, ioctl_wait}, 0);
    rx_ready = 1'b1;
    repeat (30) tick();
    check("t5_nothing", rx_q.size(), 0);
    clear_mon();
    start_dl();
    wr(8'h51); wr(8'h52);
    wait_rx(2, 200, "t5_count");
    check("t5_b0", q_at(0), 8'h51);
    check("t5_b1", q_at(1), 8'h52);
    wait_idle(200, "t5_idle", t);

    // Asynchronous reset in the middle of a gap
    rx_ready = 1'b0;
    clear_mon();
    start_dl();
    wr(8'h61); wr(8'h62); wr(8'h63); wr(8'h64);
    rx_ready = 1'b1;
    wait_rx(1, 50, "t6_first");
    @(negedge clk);
    #2;
    n_reset = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("t6_valid", {31'h0, rx_valid}, 0);
    check("t6_data", {24'h0, rx_data}, 0);
    check("t6_busy", {31'h0, busy}, 0);
    check("t6_wait", {31'h0, ioctl_wait}, 0);
    check("t6_overflow", {31'h0, overflow}, 0);
    tick();
    tick();
    n_reset = 1'b1;
    repeat (30) tick();
    check("t6_quiet", rx_q.size(), 1);
    check("t6_busy_after", {31'h0, busy}, 0);
    clear_mon();
    start_dl();
    wr(8'h7A);
    wait_rx(1, 100, "t6_count");
    check("t6_new", q_at(0), 8'h7A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
